conv_transpose2d: RTL and testbench

CONV_TRANSPOSE2D -- requirements
Module: conv_transpose2d

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_scan_ctr.sv | 73 +++++++
 rtl/conv_transpose2d.sv | 140 ++++++++++++++
 tb/tb_conv_transpose2d.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution block family: FSM encodings,
// element widths and helpers for derived sizes.
package conv_pkg;

   localparam int unsigned OUT_W  = 32;
   localparam int unsigned FMAP_W = 16;
   localparam int unsigned KERN_W = 8;
   localparam int unsigned PROD_W = FMAP_W + KERN_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_WORK  = 2'd2;

   // Feature-map side length for a valid (no padding, stride 1) convolution.
   function automatic int unsigned conv_fdim(input int unsigned img, input int unsigned k);
      return img - k + 1;
   endfunction

   // Counter/index width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/conv_scan_ctr.sv
// Nested r/c/i/j scan counter (j fastest, then i, c, r) with a last-iteration
// flag; wraps to all-zero after the final iteration.
module conv_scan_ctr
   import conv_pkg::*;
#(
   parameter int unsigned FH     = 3,
   parameter int unsigned FW     = 3,
   parameter int unsigned KERNEL = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr_i,
   input  logic                        en_i,
   output logic [cnt_w(FH)-1:0]        r_o,
   output logic [cnt_w(FW)-1:0]        c_o,
   output logic [cnt_w(KERNEL)-1:0]    i_o,
   output logic [cnt_w(KERNEL)-1:0]    j_o,
   output logic                        last_c
);

   localparam int unsigned RW = cnt_w(FH);
   localparam int unsigned CW = cnt_w(FW);
   localparam int unsigned KW = cnt_w(KERNEL);

   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic [KW-1:0] i_q, i_d;
   logic [KW-1:0] j_q, j_d;
   logic          j_wrap_c, i_wrap_c, c_wrap_c;

   assign j_wrap_c = (j_q == KW'(KERNEL - 1));
   assign i_wrap_c = j_wrap_c && (i_q == KW'(KERNEL - 1));
   assign c_wrap_c = i_wrap_c && (c_q == CW'(FW - 1));
   assign last_c   = c_wrap_c && (r_q == RW'(FH - 1));

   always_comb begin
      r_d = r_q;
      c_d = c_q;
      i_d = i_q;
      j_d = j_q;
      if (clr_i) begin
         r_d = '0;
         c_d = '0;
         i_d = '0;
         j_d = '0;
      end else if (en_i) begin
         j_d = j_wrap_c ? '0 : j_q + KW'(1);
         if (j_wrap_c) i_d = i_wrap_c ? '0 : i_q + KW'(1);
         if (i_wrap_c) c_d = c_wrap_c ? '0 : c_q + CW'(1);
         if (c_wrap_c) r_d = last_c   ? '0 : r_q + RW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
         c_q <= '0;
         i_q <= '0;
         j_q <= '0;
      end else begin
         r_q <= r_d;
         c_q <= c_d;
         i_q <= i_d;
         j_q <= j_d;
      end
   end

   assign r_o = r_q;
   assign c_o = c_q;
   assign i_o = i_q;
   assign j_o = j_q;

endmodule

// File: rtl/conv_transpose2d.sv
// Sequential 2-D transposed convolution (scatter form): clears the output image
// one element per cycle, then performs one multiply-accumulate per cycle.
module conv_transpose2d
   import conv_pkg::*;
#(
   parameter int unsigned IMG_HEIGHT = 64,
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned KERNEL     = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [FMAP_W*(IMG_HEIGHT-KERNEL+1)*(IMG_WIDTH-KERNEL+1)-1:0] fmap,
   input  logic [KERN_W*KERNEL*KERNEL-1:0]        kernel,
   output logic [OUT_W*IMG_HEIGHT*IMG_WIDTH-1:0]  out_img,
   output logic                                   busy,
   output logic                                   done
);

   localparam int unsigned FH     = conv_fdim(IMG_HEIGHT, KERNEL);
   localparam int unsigned FW     = conv_fdim(IMG_WIDTH, KERNEL);
   localparam int unsigned N_OUT  = IMG_HEIGHT * IMG_WIDTH;
   localparam int unsigned AW     = cnt_w(N_OUT);
   localparam int unsigned RW     = cnt_w(FH);
   localparam int unsigned CW     = cnt_w(FW);
   localparam int unsigned KW     = cnt_w(KERNEL);
   localparam int unsigned IW_OUT = cnt_w(OUT_W * N_OUT);
   localparam int unsigned IW_FM  = cnt_w(FMAP_W * FH * FW);
   localparam int unsigned IW_KN  = cnt_w(KERN_W * KERNEL * KERNEL);

   logic [1:0]              state_q, state_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic [AW-1:0]           clr_idx_q, clr_idx_d;
   logic [OUT_W*N_OUT-1:0]  img_q;

   logic                    scan_clr_c, scan_en_c, scan_last_c;
   logic [RW-1:0]           r_c;
   logic [CW-1:0]           c_c;
   logic [KW-1:0]           i_c, j_c;

   logic [AW-1:0]           mac_idx_c, wr_idx_c;
   logic [FMAP_W-1:0]       fmap_val_c;
   logic [KERN_W-1:0]       kern_val_c;
   logic [PROD_W-1:0]       prod_c;
   logic [OUT_W-1:0]        acc_c, wr_data_c;
   logic                    wr_en_c;

   conv_scan_ctr #(
      .FH     (FH),
      .FW     (FW),
      .KERNEL (KERNEL)
   ) u_scan (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (scan_clr_c),
      .en_i   (scan_en_c),
      .r_o    (r_c),
      .c_o    (c_c),
      .i_o    (i_c),
      .j_o    (j_c),
      .last_c (scan_last_c)
   );

   // MAC operand fetch and read-modify-write of the addressed output element.
   always_comb begin
      mac_idx_c  = AW'((32'(r_c) + 32'(i_c)) * IMG_WIDTH + 32'(c_c) + 32'(j_c));
      fmap_val_c = fmap[IW_FM'(FMAP_W * (32'(r_c) * FW + 32'(c_c))) +: FMAP_W];
      kern_val_c = kernel[IW_KN'(KERN_W * (32'(i_c) * KERNEL + 32'(j_c))) +: KERN_W];
      prod_c     = PROD_W'(fmap_val_c) * PROD_W'(kern_val_c);
      acc_c      = img_q[IW_OUT'(OUT_W * 32'(mac_idx_c)) +: OUT_W] + OUT_W'(prod_c);
   end

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      busy_d     = busy_q;
      clr_idx_d  = clr_idx_q;
      scan_clr_c = 1'b0;
      scan_en_c  = 1'b0;
      wr_en_c    = 1'b0;
      wr_idx_c   = mac_idx_c;
      wr_data_c  = acc_c;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_CLEAR;
               done_d     = 1'b0;
               busy_d     = 1'b1;
               clr_idx_d  = '0;
               scan_clr_c = 1'b1;
            end
         end
         ST_CLEAR: begin
            wr_en_c   = 1'b1;
            wr_idx_c  = clr_idx_q;
            wr_data_c = '0;
            if (clr_idx_q == AW'(N_OUT - 1)) state_d = ST_WORK;
            else                             clr_idx_d = clr_idx_q + AW'(1);
         end
         ST_WORK: begin
            wr_en_c   = 1'b1;
            scan_en_c = 1'b1;
            if (scan_last_c) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Image storage is deliberately not reset; CLEAR initialises it every run.
   always_ff @(posedge clk) begin
      if (wr_en_c) img_q[IW_OUT'(OUT_W * 32'(wr_idx_c)) +: OUT_W] <= wr_data_c;
   end

   assign out_img = img_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_conv_transpose2d.sv
// Scoreboard bench for conv_transpose2d at 4x4 output, 2x2 kernel (3x3 fmap).
module tb_conv_transpose2d;

   typedef logic [15:0][31:0] img_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic [8:0][15:0] fm_v;
   logic [3:0][7:0]  kn_v;
   logic [143:0]     fmap;
   logic [31:0]      kernel;
   logic [511:0]     out_img;
   logic             busy;
   logic             done;
   img_t             dut_img;

   int   total;
   int   bad;
   img_t exp_q[$];

   assign fmap    = fm_v;
   assign kernel  = kn_v;
   assign dut_img = out_img;

   conv_transpose2d #(
      .IMG_HEIGHT (4),
      .IMG_WIDTH  (4),
      .KERNEL     (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .fmap    (fmap),
      .kernel  (kernel),
      .out_img (out_img),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total = total + 1;
      if (act !== req) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic img_t mk_img(input int unsigned v[16]);
      img_t m;
      for (int k = 0; k < 16; k++) m[4'(k)] = 32'(v[k]);
      return m;
   endfunction

   task automatic set_in(input int unsigned f[9], input int unsigned w[4]);
      for (int k = 0; k < 9; k++) fm_v[4'(k)] = 16'(f[k]);
      for (int k = 0; k < 4; k++) kn_v[2'(k)] = 8'(w[k]);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run(input int unsigned t[16]);
      exp_q.push_back(mk_img(t));
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done();
   endtask

   // Monitor: on every rising edge of done, pop the oldest expectation and compare.
   initial begin : monitor
      logic busy_p;
      logic done_p;
      int   cnt;
      img_t e;
      busy_p = 1'b0;
      done_p = 1'b0;
      cnt    = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1 && !busy_p) cnt = 0;
         else                          cnt++;
         if (done === 1'b1 && !done_p) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_latency", 32'(cnt), 32'd52);
               chk("busy_at_done", 32'(busy), 32'd0);
               for (int k = 0; k < 16; k++)
                  chk($sformatf("out_img[%0d]", k), dut_img[4'(k)], e[4'(k)]);
            end
         end
         busy_p = (busy === 1'b1);
         done_p = (done === 1'b1);
      end
   end

   initial begin : driver
      int unsigned f[9];
      int unsigned w[4];
      int unsigned t[16];
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      fm_v  = '0;
      kn_v  = '0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      @(negedge clk) rst = 1'b0;

      // All-ones: each output counts overlapping windows.
      f = '{default: 1};
      w = '{default: 1};
      t = '{1,2,2,1, 2,4,4,2, 2,4,4,2, 1,2,2,1};
      set_in(f, w);
      run(t);
      repeat (5) @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // Asynchronous reset clears a held done without a clock edge.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk) rst = 1'b0;

      // Single impulse scattered through the kernel.
      f = '{5,0,0,0,0,0,0,0,0};
      w = '{1,2,3,4};
      t = '{5,10,0,0, 15,20,0,0, 0,0,0,0, 0,0,0,0};
      set_in(f, w);
      run(t);

      // Maximum operands: product 0xFEFF01, up to four accumulate per element.
      f = '{default: 32'hFFFF};
      w = '{default: 32'hFF};
      t = '{32'h00FEFF01, 32'h01FDFE02, 32'h01FDFE02, 32'h00FEFF01,
            32'h01FDFE02, 32'h03FBFC04, 32'h03FBFC04, 32'h01FDFE02,
            32'h01FDFE02, 32'h03FBFC04, 32'h03FBFC04, 32'h01FDFE02,
            32'h00FEFF01, 32'h01FDFE02, 32'h01FDFE02, 32'h00FEFF01};
      set_in(f, w);
      run(t);

      // Abort a run in WORK, then check the next run leaves no stale data.
      f = '{default: 1};
      w = '{default: 1};
      set_in(f, w);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (25) @(negedge clk);
      chk("busy_before_rst", 32'(busy), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      @(negedge clk) rst = 1'b0;
      f = '{5,0,0,0,0,0,0,0,0};
      w = '{1,2,3,4};
      t = '{5,10,0,0, 15,20,0,0, 0,0,0,0, 0,0,0,0};
      set_in(f, w);
      run(t);

      // Start pulses while busy are ignored; start held at done chains a new run.
      f = '{default: 1};
      w = '{default: 1};
      t = '{1,2,2,1, 2,4,4,2, 2,4,4,2, 1,2,2,1};
      set_in(f, w);
      exp_q.push_back(mk_img(t));
      t = '{1,3,5,3, 5,12,16,9, 11,24,28,15, 7,15,17,9};
      exp_q.push_back(mk_img(t));
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (19) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done();
      f = '{1,2,3,4,5,6,7,8,9};
      set_in(f, w);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_cleared", 32'(done), 32'd0);
      wait_done();
      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
